// File: rtl/state_frame_tx.sv
// Kart game-state transmitter: packs x/y/direction/game/reset into a 6-byte payload
// and sends it as one RMII frame (preamble, SFD, payload, CRC-32 FCS, gap).
module state_frame_tx #(
  parameter int IFG_CYCLES = 48,
  parameter int PRE_BYTES  = 7
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic        send_valid,
  output logic        send_ready,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  direction,
  input  logic [2:0]  game_stat,
  input  logic        reset_flag,
  output logic [1:0]  eth_txd,
  output logic        eth_txen,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_FCS  = 3'd4;
  localparam logic [2:0] S_IFG  = 3'd5;

  // The IDLE cycle itself is the last gap cycle, so IFG holds for one cycle less;
  // that lets a held send_valid restart exactly IFG_CYCLES cycles after txen drops.
  localparam int PRE_LAST = PRE_BYTES * 4 - 1;
  localparam int IFG_LAST = IFG_CYCLES - 2;
  localparam int MAX_A    = (PRE_LAST > IFG_LAST) ? PRE_LAST : IFG_LAST;
  localparam int MAX_V    = (MAX_A > 23) ? MAX_A : 23;
  localparam int CW       = $clog2(MAX_V + 1);

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [47:0]   word, word_n;
  logic [31:0]   crc, crc_n;
  logic [1:0]    txd_n;
  logic          txen_n;
  logic [5:0]    pay_base;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    word_n   = word;
    crc_n    = crc;
    txd_n    = 2'b00;
    txen_n   = 1'b0;
    pay_base = 6'd0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (send_valid) begin
          state_n = S_PRE;
          word_n  = {player_x, 1'b0, player_y, 1'b0, direction, 3'b000,
                     game_stat, 1'b0, reset_flag, 3'b000, 4'b0000};
          crc_n   = 32'hFFFFFFFF;
        end
      end
      S_PRE: if (cnt == CW'(PRE_LAST)) begin state_n = S_SFD; cnt_n = '0; end
      S_SFD: if (cnt == CW'(3))        begin state_n = S_PAY; cnt_n = '0; end
      S_PAY: if (cnt == CW'(23))       begin state_n = S_FCS; cnt_n = '0; end
      S_FCS: if (cnt == CW'(15))       begin state_n = S_IFG; cnt_n = '0; end
      S_IFG: if (cnt == CW'(IFG_LAST)) begin state_n = S_IDLE; cnt_n = '0; end
      default: begin state_n = S_IDLE; cnt_n = '0; end
    endcase

    // Outputs are computed for the state being entered so they can be registered.
    case (state_n)
      S_PRE: begin
        txen_n = 1'b1;
        txd_n  = 2'b01;
      end
      S_SFD: begin
        txen_n = 1'b1;
        txd_n  = (cnt_n == CW'(3)) ? 2'b11 : 2'b01;
      end
      S_PAY: begin
        txen_n   = 1'b1;
        pay_base = 6'd40 - {cnt_n[4:2], 3'b000} + {3'b000, cnt_n[1:0], 1'b0};
        txd_n    = word_n[pay_base +: 2];
        crc_n    = crc_step(crc_n, txd_n);
      end
      S_FCS: begin
        txen_n = 1'b1;
        txd_n  = ~crc_n[{cnt_n[3:0], 1'b0} +: 2];
      end
      default: begin
        txen_n = 1'b0;
        txd_n  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      word       <= '0;
      crc        <= 32'hFFFFFFFF;
      eth_txd    <= 2'b00;
      eth_txen   <= 1'b0;
      send_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      word       <= word_n;
      crc        <= crc_n;
      eth_txd    <= txd_n;
      eth_txen   <= txen_n;
      send_ready <= (state_n == S_IDLE);
      busy       <= (state_n != S_IDLE);
    end
  end

endmodule
